rom_reader: RTL
===============

ROM_READER -- requirements
Module: rom_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the ROM word and stream data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning the ROM address width (depth 2**ADDR_WIDTH).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port start_i, input, 1, pulse to request a burst read.
REQ-006 SHALL have port base_addr_i, input, ADDR_WIDTH, first ROM address of the burst.
REQ-007 SHALL have port len_i, input, ADDR_WIDTH+1, burst length in words (0..2**ADDR_WIDTH).
REQ-008 SHALL have port busy_o, output, 1, high while a burst is in progress.
REQ-009 SHALL have port done_o, output, 1, one-cycle pulse when a burst completes.
REQ-010 SHALL have port rom_addr_o, output, ADDR_WIDTH, registered read address to a synchronous ROM.
REQ-011 SHALL have port rom_data_i, input, DATA_WIDTH, ROM read data, valid one cycle after the ROM samples rom_addr_o.
REQ-012 SHALL have port m_data_o, output, DATA_WIDTH, stream data.
REQ-013 SHALL have ports m_valid_o (output, 1), m_ready_i (input, 1) and m_last_o (output, 1): stream handshake plus final-beat flag.

Function
REQ-014 SHALL implement FSM states IDLE, READ and DRAIN.
REQ-015 SHALL, in IDLE, on start_i=1 with len_i!=0, latch base and length, load rom_addr_o<=base_addr_i, set busy_o, and enter READ.
REQ-016 SHALL, in IDLE, on start_i=1 with len_i=0, pulse done_o the next cycle, emit no beats, and stay in IDLE.
REQ-017 SHALL ignore start_i when not in IDLE.
REQ-018 SHALL issue one read per cycle in READ only when the buffered words plus the in-flight read are fewer than 2, or equal 2 with a handshake this cycle.
REQ-019 SHALL increment rom_addr_o by 1 per issued read, modulo 2**ADDR_WIDTH, so 0xFF wraps to 0x00.
REQ-020 SHALL go from READ to DRAIN once the len-th read is issued.
REQ-021 SHALL capture each in-flight rom_data_i into a 2-entry buffer; m_data_o/m_valid_o come from the buffer head.
REQ-022 SHALL hold m_valid_o, m_data_o and m_last_o stable while m_valid_o=1 and m_ready_i=0.
REQ-023 SHALL count a beat transferred only when m_valid_o and m_ready_i are both 1.
REQ-024 SHALL assert m_last_o only with the len-th beat.
REQ-025 SHALL, in DRAIN, on the last-beat handshake, pulse done_o the next cycle, clear busy_o, and return to IDLE.
REQ-026 SHALL raise m_valid_o for the first beat 2 cycles after the start-sampling edge.
REQ-027 SHALL sustain 1 beat/cycle with m_ready_i held at 1.
REQ-028 SHALL never drop, duplicate or reorder words under any m_ready_i pattern.
REQ-029 SHALL accept len_i=2**ADDR_WIDTH and read every address exactly once.

Reset
REQ-030 SHALL, on rst_i=1, immediately clear the FSM to IDLE, empty the buffer, and discard any in-flight read.
REQ-031 SHALL hold reset values busy_o=0, done_o=0, m_valid_o=0, m_last_o=0, m_data_o=0, rom_addr_o=0.
REQ-032 SHALL accept a new start_i on the first clock edge after rst_i deasserts, including after reset mid-burst.

Structure
REQ-033 SHALL place the FSM state enum typedef in the shared package rom_reader_pkg.
REQ-034 SHALL implement the 2-entry output buffer as sub-module stream_buf2 (valid/ready in/out, DATA_WIDTH+1 wide to carry the last flag).

Verification
REQ-035 SHALL cover: ROM word at address a = a; base=0x10, len=4, ready=1 -> beats 0x10..0x13 back-to-back, first valid 2 cycles after start, last on 0x13, done_o one cycle after.
REQ-036 SHALL cover: base=0xFE, len=4 -> data 0xFE, 0xFF, 0x00, 0x01; last on 0x01.
REQ-037 SHALL cover: base=0x20, len=8, m_ready_i toggling 1,0,1,0... and random -> exactly 0x20..0x27 in order, data stable during stalls.
REQ-038 SHALL cover: len=0 -> done_o pulse next cycle, m_valid_o never high; start_i while busy -> ignored, beat count unchanged.
REQ-039 SHALL cover: rst_i asserted after 3rd beat of len=16 -> all outputs 0 at once; a new start with base=0x40, len=2 then yields 0x40, 0x41.
REQ-040 SHALL cover: base=0x00, len=256, ready=1 -> 256 beats 0x00..0xFF in 256 consecutive cycles, single last.

Source files
------------

// File: rtl/rom_reader_pkg.sv
// Shared types for the ROM burst reader.
// Holds the controller state encoding used by rom_reader.
package rom_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry valid/ready FIFO between the ROM read pipeline and the stream port.
// Head entry stays put until it is popped, so stalled output never changes.
module stream_buf2 #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push;
    logic             pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/rom_reader.sv
// Burst reader: streams len words from a synchronous ROM starting at base.
// Reads are throttled so buffered plus in-flight words never exceed two.
module rom_reader
    import rom_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o
);

    localparam logic [ADDR_WIDTH:0] ONE = 1;

    state_t              state;
    state_t              state_nx;
    logic [ADDR_WIDTH:0] rem;
    logic                inflight;
    logic                inflight_last;
    logic                accept;
    logic                issue;
    logic                pop;
    logic                done_nx;
    logic                buf_in_ready;
    logic                buf_out_valid;
    logic [DATA_WIDTH:0] buf_out_data;
    logic [1:0]          buf_count;
    logic [1:0]          occupancy;

    assign occupancy = buf_count + {1'b0, inflight};
    assign pop       = buf_out_valid & m_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        issue    = 1'b0;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        accept   = 1'b1;
                        state_nx = READ;
                    end
                end
            end
            READ: begin
                issue = (occupancy < 2'd2) ||
                        (occupancy == 2'd2 && pop);
                if (issue && rem == ONE) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && buf_out_data[DATA_WIDTH]) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem           <= '0;
            rom_addr_o    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            done_o        <= done_nx;
            inflight      <= issue;
            inflight_last <= issue && (rem == ONE);
            if (accept) begin
                rom_addr_o <= base_addr_i;
                rem        <= len_i;
            end else if (issue) begin
                rom_addr_o <= rom_addr_o + ADDR_WIDTH'(1);
                rem        <= rem - ONE;
            end
        end
    end

    // Last flag travels with the word so the stream side needs no counter.
    stream_buf2 #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_buf (
        .clk      (clk_i),
        .rst      (rst_i),
        .in_valid (inflight & buf_in_ready),
        .in_ready (buf_in_ready),
        .in_data  ({inflight_last, rom_data_i}),
        .out_valid(buf_out_valid),
        .out_ready(m_ready_i),
        .out_data (buf_out_data),
        .count    (buf_count)
    );

    assign busy_o    = (state != IDLE);
    assign m_valid_o = buf_out_valid;
    assign m_data_o  = buf_out_valid ? buf_out_data[DATA_WIDTH-1:0] : '0;
    assign m_last_o  = buf_out_valid & buf_out_data[DATA_WIDTH];

endmodule
